mem_port_arbiter: RTL and testbench

Sequential arbiter that shares the single-ported unified instruction/data memory between the fetch stage and the memory stage of the RISC-V pipeline. It issues one transaction at a time over a valid/ready request channel and a response-valid channel, generates byte enables and lane-replicated write data from the store size code, and traps misaligned data accesses without touching memory. Its per-port stall outputs feed the pipeline hazard logic; returned load data is raw 32-bit and goes to the load-extension result mux.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared single-ported instruction/data memory
// One transaction in flight; data port has priority except when fetch has been starved.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [1:0]  dm_size,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_done,
   output logic        dm_err,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state;
   logic        owner_data;
   logic [3:0]  starve_cnt;
   logic        grant_data;
   logic        misaligned;
   logic [3:0]  dm_be;
   logic [31:0] dm_wd;

   assign stall_if  = if_req & ~if_done;
   assign stall_mem = dm_req & ~dm_done;

   always_comb begin
      grant_data = dm_req & ~(if_req & (starve_cnt == 4'(STARVE_MAX)));
      misaligned = 1'b0;
      dm_be      = 4'b1111;
      dm_wd      = dm_wdata;
      case (dm_size)
         2'b00: begin
            dm_be = 4'b0001 << dm_addr[1:0];
            dm_wd = {4{dm_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = dm_addr[0];
            dm_be      = dm_addr[1] ? 4'b1100 : 4'b0011;
            dm_wd      = {2{dm_wdata[15:0]}};
         end
         default: misaligned = (dm_addr[1:0] != 2'b00);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         starve_cnt <= 4'd0;
         mem_valid  <= 1'b0;
         mem_addr   <= 32'd0;
         mem_we     <= 1'b0;
         mem_be     <= 4'd0;
         mem_wdata  <= 32'd0;
         if_done    <= 1'b0;
         dm_done    <= 1'b0;
         dm_err     <= 1'b0;
         if_rdata   <= 32'd0;
         dm_rdata   <= 32'd0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || dm_req) begin
                  owner_data <= grant_data;
                  if (grant_data) begin
                     if (!if_req)
                        starve_cnt <= 4'd0;
                     else if (starve_cnt != 4'hF)
                        starve_cnt <= starve_cnt + 4'd1;
                     mem_addr  <= {dm_addr[31:2], 2'b00};
                     mem_we    <= dm_we;
                     mem_be    <= dm_be;
                     mem_wdata <= dm_wd;
                     // Misaligned accesses complete immediately and never reach memory.
                     if (misaligned) begin
                        dm_done <= 1'b1;
                        dm_err  <= 1'b1;
                        state   <= DONE;
                     end else begin
                        mem_valid <= 1'b1;
                        state     <= REQ;
                     end
                  end else begin
                     starve_cnt <= 4'd0;
                     mem_addr   <= {if_addr[31:2], 2'b00};
                     mem_we     <= 1'b0;
                     mem_be     <= 4'b1111;
                     mem_wdata  <= 32'd0;
                     mem_valid  <= 1'b1;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid) begin
                  if (owner_data) begin
                     dm_rdata <= mem_rdata;
                     dm_done  <= 1'b1;
                     dm_err   <= 1'b0;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_done  <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            default: begin
               dm_err <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        dm_req;
   logic        dm_we;
   logic [1:0]  dm_size;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        dm_err;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   int          lat;
   bit          stable_ok;
   logic [31:0] cap_addr;
   logic [3:0]  cap_be;
   logic        cap_we;
   logic [31:0] cap_wdata;
   logic        cap_stall_if;
   logic        cap_stall_mem;

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Call with a request already presented in an IDLE cycle; returns in the done cycle.
   task automatic service(input int rwait, input logic [31:0] rd);
      lat       = 0;
      stable_ok = 1'b1;
      step();
      lat = 1;
      check("req_valid", {31'd0, mem_valid}, 32'd1);
      cap_addr      = mem_addr;
      cap_be        = mem_be;
      cap_we        = mem_we;
      cap_wdata     = mem_wdata;
      cap_stall_if  = stall_if;
      cap_stall_mem = stall_mem;
      for (int i = 0; i < rwait; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hBAD0BAD0;
         step();
         lat++;
         if (mem_valid !== 1'b1 || mem_addr !== cap_addr || mem_be !== cap_be ||
             mem_we !== cap_we || mem_wdata !== cap_wdata)
            stable_ok = 1'b0;
      end
      mem_rvalid = 1'b0;
      mem_ready  = 1'b1;
      step();
      lat++;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      step();
      lat++;
      mem_rvalid = 1'b0;
      while (!(if_done || dm_done) && lat < 40) begin
         step();
         lat++;
      end
   endtask

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
      dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'd0; dm_wdata = 32'd0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      repeat (2) step();
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_dones", {29'd0, if_done, dm_done, dm_err}, 32'd0);
      check("rst_rdata", if_rdata | dm_rdata, 32'd0);
      rst_n = 1'b1;
      step();

      // Single fetch
      if_req = 1'b1; if_addr = 32'h0000_0100;
      service(0, 32'h0050_0093);
      check("if_addr", cap_addr, 32'h100);
      check("if_be", {28'd0, cap_be}, 32'hF);
      check("if_we", {31'd0, cap_we}, 32'd0);
      check("if_latency", lat, 3);
      check("if_done", {30'd0, if_done, dm_done}, 32'b10);
      check("if_rdata", if_rdata, 32'h0050_0093);
      check("if_stall_req", {31'd0, cap_stall_if}, 32'd1);
      check("if_stall_done", {31'd0, stall_if}, 32'd0);
      if_req = 1'b0;
      step();
      check("if_done_pulse", {31'd0, if_done}, 32'd0);

      // Store byte to lane 3
      dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b00; dm_addr = 32'h203; dm_wdata = 32'hAB;
      service(0, 32'd0);
      check("sb_addr", cap_addr, 32'h200);
      check("sb_be", {28'd0, cap_be}, 32'b1000);
      check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
      check("sb_we", {31'd0, cap_we}, 32'd1);
      check("sb_done", {29'd0, if_done, dm_done, dm_err}, 32'b010);
      check("sb_stall_mem", {31'd0, cap_stall_mem}, 32'd1);
      dm_req = 1'b0;
      step();

      // Store half to upper lanes
      dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b01; dm_addr = 32'h1002; dm_wdata = 32'h1234_5678;
      service(0, 32'd0);
      check("sh_be", {28'd0, cap_be}, 32'b1100);
      check("sh_wdata", cap_wdata, 32'h5678_5678);
      dm_req = 1'b0;
      step();

      // Misaligned word load
      dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h206;
      step();
      check("mis_done", {29'd0, if_done, dm_done, dm_err}, 32'b011);
      check("mis_valid", {31'd0, mem_valid}, 32'd0);
      dm_req = 1'b0;
      step();
      check("mis_pulse", {30'd0, dm_done, dm_err}, 32'd0);
      check("mis_valid2", {31'd0, mem_valid}, 32'd0);

      // Word load with mem_ready stalled and stray rvalid during REQ
      dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h300; dm_wdata = 32'h5555_AAAA;
      service(5, 32'hDEAD_BEEF);
      check("stall_stable", {31'd0, stable_ok}, 32'd1);
      check("stall_latency", lat, 8);
      check("stall_rdata", dm_rdata, 32'hDEAD_BEEF);
      check("stall_wdata", cap_wdata, 32'h5555_AAAA);
      dm_req = 1'b0;
      step();

      // Continuous contention: D,D,D,D,F,D,D,D,D,F
      if_req = 1'b1; if_addr = 32'h400;
      dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h800;
      for (int g = 0; g < 10; g++) begin
         service(0, 32'h0);
         check($sformatf("grant%0d_fetch", g), {31'd0, if_done}, {31'd0, (g == 4 || g == 9)});
         check($sformatf("grant%0d_stall_if", g), {31'd0, cap_stall_if}, 32'd1);
         if (g == 9) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end
         step();
      end

      // Async reset while in REQ drops mem_valid without a clock edge
      if_req = 1'b1; if_addr = 32'h500;
      step();
      check("rq_valid", {31'd0, mem_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1 check("rq_rst_valid", {31'd0, mem_valid}, 32'd0);
      if_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Reset while in RESP, then a late rvalid
      dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h600;
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      dm_req = 1'b0;
      rst_n = 1'b0;
      #1 check("rs_valid", {31'd0, mem_valid}, 32'd0);
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_rvalid = 1'b0;
      check("rs_no_done", {30'd0, if_done, dm_done}, 32'd0);
      step();
      check("rs_no_done2", {30'd0, if_done, dm_done}, 32'd0);
      check("rs_rdata", dm_rdata, 32'd0);
      check("rs_idle_valid", {31'd0, mem_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
